// File: rtl/cond_eval.sv
// NZCV flag register with pending-writer scoreboard and ARM-style condition evaluation.
// Optional macro COND_NV_TRAP_EN: condition 1111 yields Pass=0 with Nv_Err=1 instead of AL.
module cond_eval #(
    parameter int unsigned PEND_W = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Flag_We,
    input  logic [3:0] New_Flag,
    input  logic       Pend_Inc,
    input  logic       Cond_Valid,
    input  logic [3:0] Cond,
    output logic       Cond_Ready,
    output logic       Pass_Valid,
    output logic       Pass,
    input  logic       Pass_Ready,
    output logic [3:0] Flag,
    output logic       Pend_Ovf,
    output logic       Nv_Err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0] pend_cnt;
    logic [3:0]        eff_flag;
    logic              out_free;
    logic              accept;
    logic              eval_pass;
    logic              eval_nv;
    logic              n, z, c, v;

    assign out_free   = !Pass_Valid || Pass_Ready;
    // A write landing this cycle retires the last pending writer, so the request may use the bypassed flags.
    assign Cond_Ready = out_free && (pend_cnt == '0 || (pend_cnt == PEND_ONE && Flag_We));
    assign accept     = Cond_Valid && Cond_Ready;
    assign eff_flag   = Flag_We ? New_Flag : Flag;
    assign {n, z, c, v} = eff_flag;

    always_comb begin
        eval_pass = 1'b0;
        eval_nv   = 1'b0;
        case (Cond)
            4'h0: eval_pass = z;
            4'h1: eval_pass = !z;
            4'h2: eval_pass = c;
            4'h3: eval_pass = !c;
            4'h4: eval_pass = n;
            4'h5: eval_pass = !n;
            4'h6: eval_pass = v;
            4'h7: eval_pass = !v;
            4'h8: eval_pass = c && !z;
            4'h9: eval_pass = !c || z;
            4'hA: eval_pass = (n == v);
            4'hB: eval_pass = (n != v);
            4'hC: eval_pass = !z && (n == v);
            4'hD: eval_pass = z || (n != v);
            4'hE: eval_pass = 1'b1;
            default: begin
`ifdef COND_NV_TRAP_EN
                eval_pass = 1'b0;
                eval_nv   = 1'b1;
`else
                eval_pass = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Flag     <= '0;
            pend_cnt <= '0;
            Pend_Ovf <= 1'b0;
        end else begin
            if (Flag_We)
                Flag <= New_Flag;
            if (Pend_Inc && !Flag_We) begin
                if (pend_cnt == PEND_MAX)
                    Pend_Ovf <= 1'b1;
                else
                    pend_cnt <= pend_cnt + PEND_ONE;
            end else if (Flag_We && !Pend_Inc && pend_cnt != '0) begin
                pend_cnt <= pend_cnt - PEND_ONE;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Pass_Valid <= 1'b0;
            Pass       <= 1'b0;
        end else if (accept) begin
            Pass_Valid <= 1'b1;
            Pass       <= eval_pass;
        end else if (Pass_Ready) begin
            Pass_Valid <= 1'b0;
        end
    end

`ifdef COND_NV_TRAP_EN
    logic nv_q;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            nv_q <= 1'b0;
        else if (accept)
            nv_q <= eval_nv;
    end
    assign Nv_Err = nv_q;
`else
    assign Nv_Err = 1'b0;
`endif

endmodule

// File: tb/tb_cond_eval.sv
// Scoreboard bench for cond_eval: a reference model predicts readiness, flags and results.
module tb_cond_eval;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Flag_We = 1'b0;
    logic [3:0] New_Flag = '0;
    logic       Pend_Inc = 1'b0;
    logic       Cond_Valid = 1'b0;
    logic [3:0] Cond = '0;
    logic       Cond_Ready;
    logic       Pass_Valid;
    logic       Pass;
    logic       Pass_Ready = 1'b1;
    logic [3:0] Flag;
    logic       Pend_Ovf;
    logic       Nv_Err;

    cond_eval #(.PEND_W(2)) dut (
        .Clk(Clk), .Rst(Rst), .Flag_We(Flag_We), .New_Flag(New_Flag),
        .Pend_Inc(Pend_Inc), .Cond_Valid(Cond_Valid), .Cond(Cond),
        .Cond_Ready(Cond_Ready), .Pass_Valid(Pass_Valid), .Pass(Pass),
        .Pass_Ready(Pass_Ready), .Flag(Flag), .Pend_Ovf(Pend_Ovf), .Nv_Err(Nv_Err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed { logic pass; logic nv; } res_t;
    res_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_flag;
    int         m_cnt;
    logic       m_ovf;
    logic       m_pv;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t model_eval(input logic [3:0] cc, input logic [3:0] f);
        res_t r;
        logic fn, fz, fc, fv;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        r.nv = 1'b0;
        case (cc)
            0: r.pass = fz;            1: r.pass = ~fz;
            2: r.pass = fc;            3: r.pass = ~fc;
            4: r.pass = fn;            5: r.pass = ~fn;
            6: r.pass = fv;            7: r.pass = ~fv;
            8: r.pass = fc & ~fz;      9: r.pass = ~fc | fz;
            10: r.pass = ~(fn ^ fv);   11: r.pass = fn ^ fv;
            12: r.pass = ~fz & ~(fn ^ fv);
            13: r.pass = fz | (fn ^ fv);
            14: r.pass = 1'b1;
            default: begin
`ifdef COND_NV_TRAP_EN
                r.pass = 1'b0; r.nv = 1'b1;
`else
                r.pass = 1'b1;
`endif
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_flag = '0; m_cnt = 0; m_ovf = 1'b0; m_pv = 1'b0;
        q.delete();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_pv"}, {7'd0, Pass_Valid}, 8'd0);
        check({tag, "_pass"}, {7'd0, Pass}, 8'd0);
        check({tag, "_flag"}, {4'd0, Flag}, 8'd0);
        check({tag, "_ovf"}, {7'd0, Pend_Ovf}, 8'd0);
        check({tag, "_nv"}, {7'd0, Nv_Err}, 8'd0);
    endtask

    // One clock: check readiness before the edge, update model at the edge, check outputs after it.
    task automatic cycle(input string tag);
        logic exp_rdy, acc;
        @(negedge Clk);
        exp_rdy = (!m_pv || Pass_Ready) && (m_cnt == 0 || (m_cnt == 1 && Flag_We));
        check({tag, "_rdy"}, {7'd0, Cond_Ready}, {7'd0, exp_rdy});
        acc = Cond_Valid && exp_rdy;
        if (m_pv && Pass_Ready && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(model_eval(Cond, Flag_We ? New_Flag : m_flag));
        @(posedge Clk);
        m_pv = acc ? 1'b1 : (Pass_Ready ? 1'b0 : m_pv);
        if (Flag_We) m_flag = New_Flag;
        if (Pend_Inc && !Flag_We) begin
            if (m_cnt == 3) m_ovf = 1'b1;
            else m_cnt++;
        end else if (Flag_We && !Pend_Inc && m_cnt > 0) begin
            m_cnt--;
        end
        #1;
        check({tag, "_pv"}, {7'd0, Pass_Valid}, {7'd0, m_pv});
        check({tag, "_flag"}, {4'd0, Flag}, {4'd0, m_flag});
        check({tag, "_ovf"}, {7'd0, Pend_Ovf}, {7'd0, m_ovf});
        if (m_pv) begin
            if (q.size() == 0) begin
                check({tag, "_sb_empty"}, 8'd1, 8'd0);
            end else begin
                check({tag, "_pass"}, {7'd0, Pass}, {7'd0, q[0].pass});
                check({tag, "_nverr"}, {7'd0, Nv_Err}, {7'd0, q[0].nv});
            end
        end
    endtask

    task automatic idle_inputs();
        Flag_We = 0; Pend_Inc = 0; Cond_Valid = 0; Pass_Ready = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:14] seq;
        seq = 15'b010110100110101;
        model_reset();
        #12;
        reset_checks("reset");
        Rst = 0;

        // EQ on reset flags, then EQ with bypassed Z=1
        Cond_Valid = 1; Cond = 4'h0;
        cycle("eq_nobyp");
        Flag_We = 1; New_Flag = 4'b0100;
        cycle("eq_byp");
        idle_inputs();
        cycle("drain1");

        // Flags N=1 V=1, sweep all conditions back to back
        Flag_We = 1; New_Flag = 4'b1001;
        cycle("setf");
        Flag_We = 0;
        for (int i = 0; i < 15; i++) begin
            Cond_Valid = 1; Cond = 4'(i);
            cycle("sweep");
            check("sweep_seq", {7'd0, Pass}, {7'd0, seq[i]});
        end
        idle_inputs();
        cycle("drain2");

        // Pending write blocks a request until the flags land
        Pend_Inc = 1;
        cycle("pinc");
        Pend_Inc = 0; Cond_Valid = 1; Cond = 4'h2;
        cycle("blocked0");
        cycle("blocked1");
        Flag_We = 1; New_Flag = 4'b0010;
        cycle("unblock");
        check("unblock_pass", {7'd0, Pass}, 8'd1);
        Flag_We = 0; Cond = 4'h3;
        cycle("cnt_zero");

        // Back-pressure holds the result and blocks new requests
        Pass_Ready = 0; Cond = 4'hE;
        cycle("bp_acc");
        Cond = 4'h0;
        for (int i = 0; i < 3; i++) cycle("bp_hold");
        Pass_Ready = 1; Cond = 4'h1;
        cycle("bp_release");
        idle_inputs();
        cycle("drain3");

        // Saturate the pending counter, then retire writers one by one
        Pend_Inc = 1;
        for (int i = 0; i < 4; i++) cycle("sat");
        Pend_Inc = 0; Cond_Valid = 1; Cond = 4'h4; Flag_We = 1; New_Flag = 4'b1000;
        for (int i = 0; i < 3; i++) cycle("retire");
        Flag_We = 0; Cond_Valid = 0;
        cycle("drain4");

        // Reserved condition
        Cond_Valid = 1; Cond = 4'hF;
        cycle("cond_f");
        Cond_Valid = 0;
        cycle("drain5");

        // Reset in the middle of activity with a result held
        Pend_Inc = 1; Pass_Ready = 0; Cond_Valid = 1; Cond = 4'h5;
        Flag_We = 1; New_Flag = 4'b0110;
        cycle("pre_rst");
        Rst = 1;
        #2;
        reset_checks("midrst");
        model_reset();
        idle_inputs();
        Rst = 0;
        Cond_Valid = 1; Cond = 4'h0;
        cycle("post_rst");
        idle_inputs();
        cycle("drain6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
